// File: rtl/output_collector.sv
// output_collector
//   Captures one selected column result per column group of the systolic
//   array in a single cycle (optional ReLU), then drains the enabled groups
//   in ascending order over a valid/ready stream tagged with the group index.
//
// Ports
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   data_in_i        column results [0:N_COLS_ARRAY-1], signed DW bits each
//   sel_col_i        per-group selects, group g at [g*SEL_WIDTH +: SEL_WIDTH];
//                    0 selects "no output" (value 0)
//   cfg_ld_i         load sel_col_i into the select registers, clear overrun_o
//                    (IDLE only)
//   grp_mask_i       group enable mask, sampled at capture
//   relu_en_i        ReLU enable, sampled at capture
//   capture_i        capture pulse
//   ready_i          downstream ready
//   valid_o, data_o, grp_o, last_o   output stream beat
//   busy_o           high while draining
//   done_o           one-cycle pulse after the final beat of a pass
//   overrun_o        sticky: a capture arrived while draining and was dropped
module output_collector #(
  parameter int N_COLS_ARRAY       = 16,
  parameter int I_WIDTH            = 8,
  parameter int F_WIDTH            = 8,
  parameter int NUMBER_GROUPS      = 4,
  parameter int NUMBER_INPUT_GROUP = (N_COLS_ARRAY + NUMBER_GROUPS - 1) / NUMBER_GROUPS,
  parameter int SEL_WIDTH          = $clog2(1 + NUMBER_INPUT_GROUP),
  parameter int GRP_WIDTH          = (NUMBER_GROUPS > 1) ? $clog2(NUMBER_GROUPS) : 1,
  localparam int DW                = I_WIDTH + F_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic signed [DW-1:0]               data_in_i [0:N_COLS_ARRAY-1],
  input  logic [NUMBER_GROUPS*SEL_WIDTH-1:0] sel_col_i,
  input  logic                               cfg_ld_i,
  input  logic [NUMBER_GROUPS-1:0]           grp_mask_i,
  input  logic                               relu_en_i,
  input  logic                               capture_i,
  input  logic                               ready_i,
  output logic                               valid_o,
  output logic signed [DW-1:0]               data_o,
  output logic [GRP_WIDTH-1:0]               grp_o,
  output logic                               last_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               overrun_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [NUMBER_GROUPS-1:0] GRP_ONE = NUMBER_GROUPS'(1'b1);

  state_t                   state_r, state_nxt;
  logic [SEL_WIDTH-1:0]     sel_r   [NUMBER_GROUPS];
  logic signed [DW-1:0]     cap_r   [NUMBER_GROUPS];
  logic signed [DW-1:0]     cap_nxt [NUMBER_GROUPS];
  logic signed [DW-1:0]     raw_s   [NUMBER_GROUPS];
  logic signed [DW-1:0]     proc_s  [NUMBER_GROUPS];
  logic [NUMBER_GROUPS-1:0] pend_r, pend_nxt, pend_left_s, low_s;
  logic [GRP_WIDTH-1:0]     grp_nxt;
  logic                     hs_s, accept_s, done_nxt, ovr_nxt, last_nxt, sel_ld_s;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [GRP_WIDTH-1:0] lowest_idx(input logic [NUMBER_GROUPS-1:0] p);
    logic [GRP_WIDTH-1:0] idx;
    idx = '0;
    for (int g = NUMBER_GROUPS - 1; g >= 0; g--) begin
      if (p[g]) idx = GRP_WIDTH'(g);
      else      idx = idx;
    end
    return idx;
  endfunction

  // Negative values clamp to zero when enabled; width is unchanged.
  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v, input logic en);
    return (en && v[DW-1]) ? '0 : v;
  endfunction

  // Per-group column select: select 0, an over-range select or a column
  // beyond the array all yield zero.
  always_comb begin
    for (int g = 0; g < NUMBER_GROUPS; g++) begin
      raw_s[g] = '0;
      for (int c = 0; c < N_COLS_ARRAY; c++) begin
        if (sel_r[g] != '0 && int'(sel_r[g]) <= NUMBER_INPUT_GROUP &&
            c == g * NUMBER_INPUT_GROUP + int'(sel_r[g]) - 1) raw_s[g] = data_in_i[c];
        else raw_s[g] = raw_s[g];
      end
      proc_s[g] = relu(raw_s[g], relu_en_i);
    end
  end

  // Next-state, pending mask and pass bookkeeping.
  always_comb begin
    done_nxt = 1'b0;
    ovr_nxt  = overrun_o;
    accept_s = 1'b0;
    hs_s     = valid_o && ready_i;
    // Isolate the lowest pending group; it is the one being presented.
    low_s       = pend_r & (~pend_r + GRP_ONE);
    pend_left_s = hs_s ? (pend_r & ~low_s) : pend_r;
    pend_nxt    = pend_r;
    case (state_r)
      IDLE: begin
        if (cfg_ld_i) ovr_nxt = 1'b0;
        else          ovr_nxt = overrun_o;
        accept_s = capture_i;
      end
      DRAIN: begin
        pend_nxt = pend_left_s;
        // A capture is only taken when it coincides with the final handshake.
        if (capture_i && pend_left_s == '0)  accept_s = 1'b1;
        else if (capture_i)                  ovr_nxt  = 1'b1;
        else if (pend_left_s == '0)          done_nxt = 1'b1;
        else                                 done_nxt = 1'b0;
      end
      default: pend_nxt = '0;
    endcase
    if (accept_s) begin
      pend_nxt = grp_mask_i;
      done_nxt = (grp_mask_i == '0);
    end else begin
      pend_nxt = pend_nxt;
    end
    for (int g = 0; g < NUMBER_GROUPS; g++) begin
      cap_nxt[g] = accept_s ? proc_s[g] : cap_r[g];
    end
    state_nxt = (pend_nxt != '0) ? DRAIN : IDLE;
    grp_nxt   = lowest_idx(pend_nxt);
    last_nxt  = (pend_nxt != '0) && ((pend_nxt & (pend_nxt - GRP_ONE)) == '0);
  end

  assign sel_ld_s = (state_r == IDLE) && cfg_ld_i;

  // Select registers, loadable only while idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int g = 0; g < NUMBER_GROUPS; g++) sel_r[g] <= '0;
    end else if (sel_ld_s) begin
      for (int g = 0; g < NUMBER_GROUPS; g++) sel_r[g] <= sel_col_i[g*SEL_WIDTH +: SEL_WIDTH];
    end else begin
      for (int g = 0; g < NUMBER_GROUPS; g++) sel_r[g] <= sel_r[g];
    end
  end

  // State, capture buffer and registered stream outputs (computed from the
  // next pending mask so ready_i never reaches an output combinationally).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= IDLE;
      pend_r    <= '0;
      for (int g = 0; g < NUMBER_GROUPS; g++) cap_r[g] <= '0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      grp_o     <= '0;
      last_o    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      pend_r    <= pend_nxt;
      cap_r     <= cap_nxt;
      valid_o   <= (pend_nxt != '0);
      data_o    <= cap_nxt[grp_nxt];
      grp_o     <= grp_nxt;
      last_o    <= last_nxt;
      busy_o    <= (state_nxt == DRAIN);
      done_o    <= done_nxt;
      overrun_o <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_output_collector.sv
module tb_output_collector;
  localparam int DW = 16;
  localparam int NC = 16;
  localparam int NG = 4;
  localparam int SW = 3;
  localparam int GW = 2;
  localparam int NC10 = 10;
  localparam int SW10 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic signed [DW-1:0] din [0:NC-1];
  logic [NG*SW-1:0]     sel_col;
  logic                 cfg_ld, relu, capture, ready;
  logic [NG-1:0]        mask;
  logic                 valid, last, busy, done, overrun;
  logic signed [DW-1:0] data;
  logic [GW-1:0]        grp;

  logic signed [DW-1:0] din10 [0:NC10-1];
  logic [NG*SW10-1:0]   sel10;
  logic                 cfg10, cap10, ready10;
  logic [NG-1:0]        mask10;
  logic                 valid10, last10, busy10, done10, overrun10;
  logic signed [DW-1:0] data10;
  logic [GW-1:0]        grp10;

  output_collector dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_in_i(din), .sel_col_i(sel_col),
    .cfg_ld_i(cfg_ld), .grp_mask_i(mask), .relu_en_i(relu), .capture_i(capture),
    .ready_i(ready), .valid_o(valid), .data_o(data), .grp_o(grp), .last_o(last),
    .busy_o(busy), .done_o(done), .overrun_o(overrun));

  output_collector #(.N_COLS_ARRAY(NC10)) dut10 (
    .clk_i(clk), .rst_n_i(rst_n), .data_in_i(din10), .sel_col_i(sel10),
    .cfg_ld_i(cfg10), .grp_mask_i(mask10), .relu_en_i(1'b0), .capture_i(cap10),
    .ready_i(ready10), .valid_o(valid10), .data_o(data10), .grp_o(grp10), .last_o(last10),
    .busy_o(busy10), .done_o(done10), .overrun_o(overrun10));

  typedef struct packed {
    logic [NG*SW-1:0]   sel;
    logic [NG-1:0]      msk;
    logic [2:0]         n;
    logic [3:0][17:0]   beats;   // {grp[1:0], data[15:0]}, beat 0 first
  } vec_t;

  typedef struct packed {
    logic [GW-1:0] g;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t sbq [$];
  int    checks = 0;
  int    failures = 0;
  int    done_cnt = 0;
  logic  last_done, last_busy;
  vec_t  vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: observe at the falling edge, return #1 after the rising edge.
  task automatic step();
    beat_t e;
    @(negedge clk);
    if (valid && ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual grp=%0d data=%0h required none", grp, data);
      end else begin
        e = sbq.pop_front();
        checks++;
        if ({grp, data, last} !== {e.g, e.d, e.l}) begin
          failures++;
          $display("FAIL beat actual grp=%0d data=%0h last=%0b required grp=%0d data=%0h last=%0b",
                   grp, data, last, e.g, e.d, e.l);
        end
      end
    end
    if (done) done_cnt++;
    last_done = done;
    last_busy = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input int budget, output int cyc);
    int d0;
    d0 = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      step();
      cyc++;
    end
    chk("pass_done_seen", 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic push_vec(input vec_t v);
    for (int k = 0; k < int'(v.n); k++)
      sbq.push_back({v.beats[k][17:16], v.beats[k][15:0], (k == int'(v.n) - 1)});
  endtask

  task automatic cfg_sel(input logic [NG*SW-1:0] s);
    sel_col = s;
    cfg_ld = 1'b1;
    step();
    cfg_ld = 1'b0;
  endtask

  task automatic do_capture(input logic [NG-1:0] m);
    mask = m;
    capture = 1'b1;
    step();
    capture = 1'b0;
  endtask

  initial begin
    int cyc;
    int d0;
    vec_t v;
    vecs[0] = '{sel: {3'd4, 3'd3, 3'd2, 3'd1}, msk: 4'b1111, n: 3'd4,
                beats: {{2'd3, 16'd1500}, {2'd2, 16'd1000}, {2'd1, 16'd500}, {2'd0, 16'd0}}};
    vecs[1] = '{sel: {3'd0, 3'd3, 3'd2, 3'd1}, msk: 4'b1010, n: 3'd2,
                beats: {18'd0, 18'd0, {2'd3, 16'd0}, {2'd1, 16'd500}}};
    vecs[2] = '{sel: {3'd4, 3'd4, 3'd4, 3'd4}, msk: 4'b0101, n: 3'd2,
                beats: {18'd0, 18'd0, {2'd2, 16'd1100}, {2'd0, 16'd300}}};
    vecs[3] = '{sel: {3'd2, 3'd1, 3'd0, 3'd5}, msk: 4'b1111, n: 3'd4,
                beats: {{2'd3, 16'd1300}, {2'd2, 16'd800}, {2'd1, 16'd0}, {2'd0, 16'd0}}};
    vecs[4] = '{sel: {3'd3, 3'd0, 3'd0, 3'd0}, msk: 4'b1000, n: 3'd1,
                beats: {18'd0, 18'd0, 18'd0, {2'd3, 16'd1400}}};
    vecs[5] = '{sel: {3'd1, 3'd1, 3'd1, 3'd1}, msk: 4'b0000, n: 3'd0, beats: 72'd0};
    vecs[6] = '{sel: {3'd1, 3'd2, 3'd3, 3'd4}, msk: 4'b0110, n: 3'd2,
                beats: {18'd0, 18'd0, {2'd2, 16'd900}, {2'd1, 16'd600}}};
    vecs[7] = '{sel: {3'd7, 3'd6, 3'd0, 3'd2}, msk: 4'b1101, n: 3'd3,
                beats: {18'd0, {2'd3, 16'd0}, {2'd2, 16'd0}, {2'd0, 16'd100}}};

    for (int c = 0; c < NC; c++) din[c] = 16'(c * 100);
    for (int c = 0; c < NC10; c++) din10[c] = 16'(c * 100);
    sel_col = '0; cfg_ld = 1'b0; mask = '0; relu = 1'b0; capture = 1'b0; ready = 1'b1;
    sel10 = '0; cfg10 = 1'b0; mask10 = '0; cap10 = 1'b0; ready10 = 1'b1;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #3;
    chk("reset_outputs", {valid, busy, done, last, overrun, data, grp}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven passes with ready held high.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      cfg_sel(v.sel);
      push_vec(v);
      do_capture(v.msk);
      run_pass(20, cyc);
      chk("pass_cycles", cyc, 32'(int'(v.n) + 1));
      chk("busy_at_done", 32'(last_busy), 32'd0);
      chk("sb_empty", sbq.size(), 32'd0);
      step();
      chk("done_one_cycle", 32'(last_done), 32'd0);
    end

    // Backpressure while group 1 is presented.
    cfg_sel(vecs[0].sel);
    push_vec(vecs[0]);
    do_capture(vecs[0].msk);
    step();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {valid, last, grp, data}, {1'b1, 1'b0, 2'd1, 16'd500});
      step();
    end
    ready = 1'b1;
    run_pass(20, cyc);
    chk("bp_cycles", cyc, 32'd4);
    chk("bp_sb_empty", sbq.size(), 32'd0);

    // ReLU on a negative column value.
    din[0] = -16'sd5;
    cfg_sel({3'd0, 3'd0, 3'd0, 3'd1});
    relu = 1'b1;
    sbq.push_back({2'd0, 16'h0000, 1'b1});
    do_capture(4'b0001);
    run_pass(20, cyc);
    relu = 1'b0;
    sbq.push_back({2'd0, 16'hFFFB, 1'b1});
    do_capture(4'b0001);
    run_pass(20, cyc);
    chk("relu_sb_empty", sbq.size(), 32'd0);
    din[0] = 16'sd0;

    // Capture coincident with the final handshake starts the next pass.
    cfg_sel(vecs[1].sel);
    push_vec(vecs[1]);
    do_capture(vecs[1].msk);
    step();
    chk("coinc_last", {valid, last, grp}, {1'b1, 1'b1, 2'd3});
    sbq.push_back({2'd2, 16'd1000, 1'b1});
    d0 = done_cnt;
    do_capture(4'b0100);
    chk("coinc_next", {valid, grp, data}, {1'b1, 2'd2, 16'd1000});
    run_pass(20, cyc);
    chk("coinc_cycles", cyc, 32'd2);
    chk("coinc_done_count", done_cnt - d0, 32'd1);
    chk("coinc_no_overrun", 32'(overrun), 32'd0);

    // Capture mid-drain is dropped and flagged.
    cfg_sel(vecs[0].sel);
    push_vec(vecs[0]);
    do_capture(vecs[0].msk);
    step();
    do_capture(4'b0001);
    chk("overrun_set", 32'(overrun), 32'd1);
    run_pass(20, cyc);
    chk("overrun_cycles", cyc, 32'd3);
    chk("overrun_sb_empty", sbq.size(), 32'd0);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    cfg_sel(vecs[0].sel);
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Asynchronous reset mid-drain.
    push_vec(vecs[0]);
    do_capture(vecs[0].msk);
    step();
    do_capture(4'b1111);
    chk("overrun_pre_reset", 32'(overrun), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {valid, busy, last, done, overrun, data, grp}, 32'd0);
    sbq.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_after_reset", 32'(valid), 32'd0);
    end
    // Select registers were reset to 0, so every group yields 0.
    for (int k = 0; k < 4; k++) sbq.push_back({2'(k), 16'd0, (k == 3)});
    do_capture(4'b1111);
    run_pass(20, cyc);
    chk("sel_reset_cycles", cyc, 32'd5);

    // Ten-column array: group 3 select 2 falls past the last column.
    sel10 = {2'd2, 2'd2, 2'd0, 2'd0};
    cfg10 = 1'b1;
    step();
    cfg10 = 1'b0;
    mask10 = 4'b1100;
    cap10 = 1'b1;
    step();
    cap10 = 1'b0;
    chk("n10_beat0", {valid10, busy10, last10, grp10, data10}, {1'b1, 1'b1, 1'b0, 2'd2, 16'd700});
    step();
    chk("n10_beat1", {valid10, last10, grp10, data10}, {1'b1, 1'b1, 2'd3, 16'd0});
    step();
    chk("n10_done", {done10, valid10, overrun10}, {1'b1, 1'b0, 1'b0});

    chk("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
